// File: rtl/axis_tx_arbiter.sv
// Packet-atomic round-robin arbiter that merges NUM_SRC AXI-stream sources onto one registered output.
// The output beat is tagged with the index of the source that produced it.
module axis_tx_arbiter #(
  parameter int NUM_SRC         = 4,
  parameter int AXIS_DATA_WIDTH = 8,
  parameter int MAX_BEATS       = 16,
  parameter int ID_WIDTH        = 3
) (
  input  logic                               axis_aclk_i,
  input  logic                               axis_aresetn_i,
  input  logic [NUM_SRC-1:0]                 s_axis_tvalid_i,
  output logic [NUM_SRC-1:0]                 s_axis_tready_o,
  input  logic [NUM_SRC*AXIS_DATA_WIDTH-1:0] s_axis_tdata_i,
  input  logic [NUM_SRC-1:0]                 s_axis_tlast_i,
  input  logic                               m_axis_tready_i,
  output logic                               m_axis_tvalid_o,
  output logic [AXIS_DATA_WIDTH-1:0]         m_axis_tdata_o,
  output logic                               m_axis_tlast_o,
  output logic [ID_WIDTH-1:0]                m_axis_tid_o,
  output logic                               busy_o,
  output logic [NUM_SRC-1:0]                 grant_o
);

  localparam int SW = $clog2(NUM_SRC);
  localparam int BW = (MAX_BEATS > 0) ? $clog2(MAX_BEATS + 1) : 1;
  localparam logic [BW-1:0] LAST_CNT = (MAX_BEATS > 0) ? BW'(MAX_BEATS - 1) : '0;

  // Handshake: a beat moves on an interface at a rising edge where tvalid and tready are both 1;
  // tvalid never depends on tready, and a presented output beat is held until it is taken.

  typedef enum logic {IDLE, LOCK} state_t;

  state_t                     state_q;
  logic [NUM_SRC-1:0]         grant_q;
  logic [SW-1:0]              gidx_q;
  logic [SW-1:0]              rr_ptr_q;
  logic [BW-1:0]              beat_cnt_q;

  logic                       pick_vld;
  logic [SW-1:0]              pick_idx;
  logic [SW-1:0]              scan_idx;
  logic                       src_vld;
  logic                       src_last;
  logic [AXIS_DATA_WIDTH-1:0] src_data;
  logic                       out_ready;
  logic                       accept;
  logic                       load_last;

  // First requester at or after rr_ptr, wrapping modulo NUM_SRC.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    scan_idx = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      scan_idx = SW'((int'(rr_ptr_q) + i) % NUM_SRC);
      if (!pick_vld && s_axis_tvalid_i[scan_idx]) begin
        pick_vld = 1'b1;
        pick_idx = scan_idx;
      end
    end
  end

  always_comb begin
    src_vld  = 1'b0;
    src_last = 1'b0;
    src_data = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (gidx_q == SW'(k)) begin
        src_vld  = s_axis_tvalid_i[k];
        src_last = s_axis_tlast_i[k];
        src_data = s_axis_tdata_i[k*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
      end
    end
  end

  assign out_ready       = !m_axis_tvalid_o || m_axis_tready_i;
  assign s_axis_tready_o = (state_q == LOCK && out_ready) ? grant_q : '0;
  assign accept          = (state_q == LOCK) && out_ready && src_vld;
  // A burst-limit break looks like a normal end of packet downstream.
  assign load_last       = src_last || ((MAX_BEATS != 0) && (beat_cnt_q == LAST_CNT));
  assign busy_o          = (state_q == LOCK);
  assign grant_o         = grant_q;

  always_ff @(posedge axis_aclk_i or negedge axis_aresetn_i) begin
    if (!axis_aresetn_i) begin
      state_q         <= IDLE;
      grant_q         <= '0;
      gidx_q          <= '0;
      rr_ptr_q        <= '0;
      beat_cnt_q      <= '0;
      m_axis_tvalid_o <= 1'b0;
      m_axis_tdata_o  <= '0;
      m_axis_tlast_o  <= 1'b0;
      m_axis_tid_o    <= '0;
    end else begin
      if (accept) begin
        m_axis_tvalid_o <= 1'b1;
        m_axis_tdata_o  <= src_data;
        m_axis_tlast_o  <= load_last;
        m_axis_tid_o    <= ID_WIDTH'(gidx_q);
      end else if (m_axis_tvalid_o && m_axis_tready_i) begin
        m_axis_tvalid_o <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            state_q    <= LOCK;
            grant_q    <= NUM_SRC'(1) << pick_idx;
            gidx_q     <= pick_idx;
            beat_cnt_q <= '0;
          end
        end
        LOCK: begin
          if (accept) begin
            beat_cnt_q <= beat_cnt_q + 1'b1;
            if (load_last) begin
              state_q  <= IDLE;
              grant_q  <= '0;
              rr_ptr_q <= (gidx_q == SW'(NUM_SRC - 1)) ? '0 : gidx_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_tx_arbiter.sv
// Directed bench for axis_tx_arbiter: per-source beat memories feed the inputs, accepted output
// beats are captured as {tid, last, data} and compared against hand-written sequences.
module tb_axis_tx_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  s_axis_tvalid_i;
  logic [3:0]  s_axis_tready_o;
  logic [31:0] s_axis_tdata_i;
  logic [3:0]  s_axis_tlast_i;
  logic        m_axis_tready_i;
  logic        m_axis_tvalid_o;
  logic [7:0]  m_axis_tdata_o;
  logic        m_axis_tlast_o;
  logic [2:0]  m_axis_tid_o;
  logic        busy_o;
  logic [3:0]  grant_o;

  int checks;
  int failures;

  logic [8:0]  src_mem [4][32];
  int          src_wr [4];
  int          src_rd [4];
  bit          src_en [4];
  logic [11:0] obs_q[$];
  logic [11:0] exp_q[$];

  axis_tx_arbiter #(
    .NUM_SRC(4), .AXIS_DATA_WIDTH(8), .MAX_BEATS(16), .ID_WIDTH(3)
  ) dut (
    .axis_aclk_i     (clk),
    .axis_aresetn_i  (rst_n),
    .s_axis_tvalid_i (s_axis_tvalid_i),
    .s_axis_tready_o (s_axis_tready_o),
    .s_axis_tdata_i  (s_axis_tdata_i),
    .s_axis_tlast_i  (s_axis_tlast_i),
    .m_axis_tready_i (m_axis_tready_i),
    .m_axis_tvalid_o (m_axis_tvalid_o),
    .m_axis_tdata_o  (m_axis_tdata_o),
    .m_axis_tlast_o  (m_axis_tlast_o),
    .m_axis_tid_o    (m_axis_tid_o),
    .busy_o          (busy_o),
    .grant_o         (grant_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] mk(input logic [2:0] tid, input logic last, input logic [7:0] data);
    return {tid, last, data};
  endfunction

  // driver tasks
  task automatic enq(input int k, input logic [7:0] d, input logic l);
    src_mem[k][src_wr[k]] = {l, d};
    src_wr[k]++;
  endtask

  task automatic drive_sources();
    for (int k = 0; k < 4; k++) begin
      if (src_en[k] && src_rd[k] < src_wr[k]) begin
        s_axis_tvalid_i[k]       = 1'b1;
        s_axis_tdata_i[k*8 +: 8] = src_mem[k][src_rd[k]][7:0];
        s_axis_tlast_i[k]        = src_mem[k][src_rd[k]][8];
      end else begin
        s_axis_tvalid_i[k]       = 1'b0;
        s_axis_tdata_i[k*8 +: 8] = 8'($urandom_range(0, 255));
        s_axis_tlast_i[k]        = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic clear_sources();
    for (int k = 0; k < 4; k++) begin
      src_wr[k] = 0;
      src_rd[k] = 0;
      src_en[k] = 1'b1;
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  // Called just after a falling edge: record handshakes that the next rising edge completes.
  task automatic tick();
    #1;
    if (m_axis_tvalid_o && m_axis_tready_i)
      obs_q.push_back({m_axis_tid_o, m_axis_tlast_o, m_axis_tdata_o});
    for (int k = 0; k < 4; k++)
      if (s_axis_tvalid_i[k] && s_axis_tready_o[k]) src_rd[k]++;
    @(posedge clk);
    @(negedge clk);
    drive_sources();
  endtask

  task automatic run_until(input int n, input int budget);
    int t;
    t = 0;
    while (obs_q.size() < n && t < budget) begin
      tick();
      t++;
    end
    checks++;
    if (obs_q.size() < n) begin
      failures++;
      $display("FAIL timeout: got %0d beats, required %0d", obs_q.size(), n);
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    m_axis_tready_i = 1'b1;
    clear_sources();
    drive_sources();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // scenarios
  task automatic test_reset();
    rst_n = 1'b0;
    m_axis_tready_i = 1'b1;
    clear_sources();
    for (int k = 0; k < 4; k++) enq(k, 8'(8'h30 + k), 1'b1);
    drive_sources();
    @(negedge clk);
    #1;
    checks += 7;
    if (m_axis_tvalid_o !== 1'b0) begin failures++; $display("FAIL rst_tvalid: got %b required 0", m_axis_tvalid_o); end
    if (m_axis_tdata_o !== 8'h00) begin failures++; $display("FAIL rst_tdata: got %h required 00", m_axis_tdata_o); end
    if (m_axis_tlast_o !== 1'b0) begin failures++; $display("FAIL rst_tlast: got %b required 0", m_axis_tlast_o); end
    if (m_axis_tid_o !== 3'd0) begin failures++; $display("FAIL rst_tid: got %0d required 0", m_axis_tid_o); end
    if (busy_o !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b required 0", busy_o); end
    if (grant_o !== 4'b0000) begin failures++; $display("FAIL rst_grant: got %b required 0000", grant_o); end
    if (s_axis_tready_o !== 4'b0000) begin failures++; $display("FAIL rst_s_tready: got %b required 0000", s_axis_tready_o); end
    rst_n = 1'b1;
    tick();
    checks += 4;
    if (grant_o !== 4'b0001) begin failures++; $display("FAIL first_grant: got %b required 0001", grant_o); end
    if (busy_o !== 1'b1) begin failures++; $display("FAIL first_busy: got %b required 1", busy_o); end
    if (m_axis_tvalid_o !== 1'b0) begin failures++; $display("FAIL edge1_tvalid: got %b required 0", m_axis_tvalid_o); end
    if (s_axis_tready_o !== 4'b0001) begin failures++; $display("FAIL edge1_s_tready: got %b required 0001", s_axis_tready_o); end
    tick();
    checks += 3;
    if (m_axis_tvalid_o !== 1'b1) begin failures++; $display("FAIL edge2_tvalid: got %b required 1", m_axis_tvalid_o); end
    if (m_axis_tid_o !== 3'd0) begin failures++; $display("FAIL edge2_tid: got %0d required 0", m_axis_tid_o); end
    if (m_axis_tdata_o !== 8'h30) begin failures++; $display("FAIL edge2_tdata: got %h required 30", m_axis_tdata_o); end
  endtask

  task automatic test_round_robin();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      enq(0, 8'(8'hA0 + i), i == 2);
      enq(2, 8'(8'hB0 + i), i == 2);
      enq(3, 8'(8'hC0 + i), i == 2);
    end
    drive_sources();
    for (int i = 0; i < 3; i++) exp_q.push_back(mk(3'd0, i == 2, 8'(8'hA0 + i)));
    for (int i = 0; i < 3; i++) exp_q.push_back(mk(3'd2, i == 2, 8'(8'hB0 + i)));
    for (int i = 0; i < 3; i++) exp_q.push_back(mk(3'd3, i == 2, 8'(8'hC0 + i)));
    run_until(9, 60);
    repeat (2) tick();
    checks++;
    if (obs_q.size() != 9) begin failures++; $display("FAIL rr_count: got %0d required 9", obs_q.size()); end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL rr_beat%0d: got %h required %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_burst_limit();
    apply_reset();
    for (int i = 0; i < 20; i++) enq(1, 8'(8'h10 + i), i == 19);
    drive_sources();
    tick();
    enq(0, 8'hD0, 1'b1);
    drive_sources();
    for (int i = 0; i < 16; i++) exp_q.push_back(mk(3'd1, i == 15, 8'(8'h10 + i)));
    exp_q.push_back(mk(3'd0, 1'b1, 8'hD0));
    for (int i = 16; i < 20; i++) exp_q.push_back(mk(3'd1, i == 19, 8'(8'h10 + i)));
    run_until(21, 100);
    for (int i = 0; i < 21; i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL burst_beat%0d: got %h required %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    for (int i = 0; i < 4; i++) enq(3, 8'(8'hE0 + i), i == 3);
    drive_sources();
    run_until(1, 20);
    m_axis_tready_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks += 3;
      if (m_axis_tvalid_o !== 1'b1) begin failures++; $display("FAIL bp_tvalid c%0d: got %b required 1", c, m_axis_tvalid_o); end
      if (m_axis_tdata_o !== 8'hE1) begin failures++; $display("FAIL bp_tdata c%0d: got %h required e1", c, m_axis_tdata_o); end
      if (s_axis_tready_o !== 4'b0000) begin failures++; $display("FAIL bp_s_tready c%0d: got %b required 0000", c, s_axis_tready_o); end
    end
    m_axis_tready_i = 1'b1;
    run_until(4, 20);
    repeat (3) tick();
    checks++;
    if (obs_q.size() != 4) begin failures++; $display("FAIL bp_count: got %0d required 4", obs_q.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs_q[i] !== mk(3'd3, i == 3, 8'(8'hE0 + i))) begin
        failures++;
        $display("FAIL bp_beat%0d: got %h required %h", i, obs_q[i], mk(3'd3, i == 3, 8'(8'hE0 + i)));
      end
    end
  endtask

  task automatic test_source_stall();
    int t;
    apply_reset();
    for (int i = 0; i < 4; i++) enq(2, 8'(8'h20 + i), i == 3);
    drive_sources();
    tick();
    enq(1, 8'h50, 1'b1);
    drive_sources();
    t = 0;
    while (src_rd[2] < 2 && t < 20) begin
      tick();
      t++;
    end
    src_en[2] = 1'b0;
    drive_sources();
    for (int c = 0; c < 3; c++) begin
      tick();
      checks += 3;
      if (grant_o !== 4'b0100) begin failures++; $display("FAIL stall_grant c%0d: got %b required 0100", c, grant_o); end
      if (busy_o !== 1'b1) begin failures++; $display("FAIL stall_busy c%0d: got %b required 1", c, busy_o); end
      if (s_axis_tready_o[1] !== 1'b0) begin failures++; $display("FAIL stall_src1_ready c%0d: got %b required 0", c, s_axis_tready_o[1]); end
    end
    src_en[2] = 1'b1;
    drive_sources();
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(3'd2, i == 3, 8'(8'h20 + i)));
    exp_q.push_back(mk(3'd1, 1'b1, 8'h50));
    run_until(5, 40);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL stall_beat%0d: got %h required %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid_packet();
    apply_reset();
    enq(2, 8'h70, 1'b1);
    drive_sources();
    run_until(1, 20);
    for (int i = 0; i < 4; i++) enq(3, 8'(8'h80 + i), i == 3);
    drive_sources();
    run_until(2, 20);
    checks += 2;
    if (grant_o !== 4'b1000) begin failures++; $display("FAIL pre_rst_grant: got %b required 1000", grant_o); end
    if (m_axis_tvalid_o !== 1'b1) begin failures++; $display("FAIL pre_rst_tvalid: got %b required 1", m_axis_tvalid_o); end
    #2;
    rst_n = 1'b0;
    #1;
    checks += 4;
    if (m_axis_tvalid_o !== 1'b0) begin failures++; $display("FAIL mid_rst_tvalid: got %b required 0", m_axis_tvalid_o); end
    if (grant_o !== 4'b0000) begin failures++; $display("FAIL mid_rst_grant: got %b required 0000", grant_o); end
    if (busy_o !== 1'b0) begin failures++; $display("FAIL mid_rst_busy: got %b required 0", busy_o); end
    if (s_axis_tready_o !== 4'b0000) begin failures++; $display("FAIL mid_rst_s_tready: got %b required 0000", s_axis_tready_o); end
    clear_sources();
    drive_sources();
    @(negedge clk);
    rst_n = 1'b1;
    enq(3, 8'h93, 1'b1);
    enq(1, 8'h91, 1'b1);
    drive_sources();
    run_until(2, 30);
    checks += 2;
    if (obs_q[0] !== mk(3'd1, 1'b1, 8'h91)) begin failures++; $display("FAIL post_rst_beat0: got %h required %h", obs_q[0], mk(3'd1, 1'b1, 8'h91)); end
    if (obs_q[1] !== mk(3'd3, 1'b1, 8'h93)) begin failures++; $display("FAIL post_rst_beat1: got %h required %h", obs_q[1], mk(3'd3, 1'b1, 8'h93)); end
  endtask

  // sequence and final report
  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    m_axis_tready_i = 1'b1;
    s_axis_tvalid_i = '0;
    s_axis_tdata_i = '0;
    s_axis_tlast_i = '0;
    clear_sources();
    @(negedge clk);
    test_reset();
    test_round_robin();
    test_burst_limit();
    test_backpressure();
    test_source_stall();
    test_reset_mid_packet();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
